// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin owner selection for a shared serial bus, with a
//            mandatory idle turnaround between owners. Optional macro
//            BUS_ARB_TIMEOUT_EN revokes a grant that never asserts UTIL.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_MASTERS-1:0]         M_REQ,
  input  logic [NUM_MASTERS-1:0]         M_UTIL,
  input  logic [NUM_MASTERS-1:0]         M_DONE,
  input  logic [NUM_MASTERS-1:0]         M_RW,
  input  logic [NUM_MASTERS-1:0]         M_BUS_OUT,
  output logic [NUM_MASTERS-1:0]         B_GRANT,
  output logic                           S_BUS_OUT,
  output logic                           S_RW,
  output logic                           S_UTIL,
  output logic                           BUS_BUSY,
  output logic [$clog2(NUM_MASTERS)-1:0] OWNER_ID
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                           ARB_TIMEOUT
`endif
);

  localparam int            OW      = $clog2(NUM_MASTERS);
  localparam logic [OW-1:0] LAST_ID = OW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic                   busy_q,  busy_d;
  logic [OW-1:0]          sel;
  logic                   sel_found;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Scan starting just after the last owner so it gets lowest priority.
  always_comb begin
    sel       = owner_q;
    sel_found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!sel_found && M_REQ[(int'(owner_q) + i) % NUM_MASTERS]) begin
        sel_found = 1'b1;
        sel       = OW'((int'(owner_q) + i) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d      = ST_ARMED;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          busy_d       = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d        = 8'd0;
`endif
        end
      end
      ST_ARMED: begin
        // A request drop outranks UTIL arriving in the same cycle.
        if (!M_REQ[owner_q]) begin
          state_d = ST_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (M_UTIL[owner_q]) begin
          state_d = ST_BUSY;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = ST_TURN;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_BUSY: begin
        // DONE is only honoured here so a stale level from the previous
        // transaction cannot end the next one before UTIL rises.
        if (M_DONE[owner_q] || !M_REQ[owner_q]) begin
          state_d = ST_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= LAST_ID;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign ARB_TIMEOUT = timeout_q;
`endif

  assign B_GRANT   = grant_q;
  assign BUS_BUSY  = busy_q;
  assign OWNER_ID  = owner_q;
  assign S_BUS_OUT = busy_q & M_BUS_OUT[owner_q];
  assign S_RW      = busy_q & M_RW[owner_q];
  assign S_UTIL    = busy_q & M_UTIL[owner_q];

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter: directed scenarios plus a
//            randomized run compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] M_REQ, M_UTIL, M_DONE, M_RW, M_BUS_OUT;
  logic [N-1:0] B_GRANT;
  logic         S_BUS_OUT, S_RW, S_UTIL, BUS_BUSY;
  logic [$clog2(N)-1:0] OWNER_ID;
`ifdef BUS_ARB_TIMEOUT_EN
  logic         ARB_TIMEOUT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .M_REQ     (M_REQ),
    .M_UTIL    (M_UTIL),
    .M_DONE    (M_DONE),
    .M_RW      (M_RW),
    .M_BUS_OUT (M_BUS_OUT),
    .B_GRANT   (B_GRANT),
    .S_BUS_OUT (S_BUS_OUT),
    .S_RW      (S_RW),
    .S_UTIL    (S_UTIL),
    .BUS_BUSY  (BUS_BUSY),
    .OWNER_ID  (OWNER_ID)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .ARB_TIMEOUT (ARB_TIMEOUT)
`endif
  );

  always #5 CLK = ~CLK;

  // Transaction-level model: which master owns the bus and in which phase
  // of its tenure it is (waiting for UTIL, transferring, or in the gap).
  localparam int P_IDLE = 0, P_WAIT = 1, P_XFER = 2, P_GAP = 3;
  int m_phase, m_owner, m_cnt;
  bit m_to;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_owner = N - 1;
    m_cnt   = 0;
    m_to    = 0;
  endtask

  task automatic model_edge();
    bit found;
    int nxt;
    m_to  = 0;
    found = 0;
    nxt   = m_owner;
    case (m_phase)
      P_IDLE: begin
        for (int k = 1; k <= N; k++) begin
          if (!found && M_REQ[(m_owner + k) % N]) begin
            found = 1;
            nxt   = (m_owner + k) % N;
          end
        end
        if (found) begin
          m_owner = nxt;
          m_phase = P_WAIT;
          m_cnt   = 0;
        end
      end
      P_WAIT: begin
        if (!M_REQ[m_owner])      m_phase = P_GAP;
        else if (M_UTIL[m_owner]) m_phase = P_XFER;
        else begin
`ifdef BUS_ARB_TIMEOUT_EN
          m_cnt = m_cnt + 1;
          if (m_cnt >= TO) begin
            m_phase = P_GAP;
            m_to    = 1;
          end
`endif
        end
      end
      P_XFER: if (M_DONE[m_owner] || !M_REQ[m_owner]) m_phase = P_GAP;
      default: m_phase = P_IDLE;
    endcase
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_phase == P_WAIT || m_phase == P_XFER) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    M_REQ = '0; M_UTIL = '0; M_DONE = '0; M_RW = '0; M_BUS_OUT = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge CLK);
    #1;
    n_checks++; if (B_GRANT !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", B_GRANT); end
    n_checks++; if (BUS_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", BUS_BUSY); end
    n_checks++; if (OWNER_ID !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %0d want 1", OWNER_ID); end
    M_BUS_OUT = 2'b11; M_RW = 2'b11; M_UTIL = 2'b11;
    #1;
    n_checks++; if ({S_BUS_OUT, S_RW, S_UTIL} !== 3'b000) begin n_fail++; $display("FAIL reset_smux: got %b want 000", {S_BUS_OUT, S_RW, S_UTIL}); end
    clear_inputs();
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    do_reset();
    M_REQ = 2'b01;
    tick();
    n_checks++; if ({B_GRANT, BUS_BUSY, OWNER_ID} !== 4'b01_1_0) begin n_fail++; $display("FAIL basic_grant: got %b want 0110", {B_GRANT, BUS_BUSY, OWNER_ID}); end
    tick();
    n_checks++; if (B_GRANT !== 2'b01) begin n_fail++; $display("FAIL basic_armed_hold: got %b want 01", B_GRANT); end
    M_UTIL = 2'b01;
    tick();
    n_checks++; if ({B_GRANT, S_UTIL} !== 3'b01_1) begin n_fail++; $display("FAIL basic_busy: got %b want 011", {B_GRANT, S_UTIL}); end
    M_DONE = 2'b01;
    tick();
    n_checks++; if ({B_GRANT, BUS_BUSY, OWNER_ID} !== 4'b00_0_0) begin n_fail++; $display("FAIL basic_turn: got %b want 0000", {B_GRANT, BUS_BUSY, OWNER_ID}); end
    clear_inputs();
    tick();
    n_checks++; if ({B_GRANT, BUS_BUSY} !== 3'b00_0) begin n_fail++; $display("FAIL basic_idle: got %b want 000", {B_GRANT, BUS_BUSY}); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expg;
    int waitc;
    do_reset();
    M_REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      expg  = (k % 2 == 0) ? 2'b01 : 2'b10;
      waitc = 0;
      tick();
      while (B_GRANT === 2'b00 && waitc < 8) begin
        tick();
        waitc++;
      end
      n_checks++; if (B_GRANT !== expg) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", k, B_GRANT, expg); end
      M_UTIL = expg;
      tick();
      M_DONE = expg;
      tick();
      n_checks++; if (B_GRANT !== 2'b00) begin n_fail++; $display("FAIL rr_gap[%0d]: got %b want 00", k, B_GRANT); end
      M_UTIL = '0;
      M_DONE = '0;
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_mux();
    do_reset();
    M_REQ = 2'b10;
    tick();
    M_UTIL = 2'b10;
    tick();
    M_BUS_OUT = 2'b10; M_RW = 2'b10;
    #1;
    n_checks++; if ({S_BUS_OUT, S_RW, S_UTIL} !== 3'b111) begin n_fail++; $display("FAIL mux_owner1: got %b want 111", {S_BUS_OUT, S_RW, S_UTIL}); end
    M_BUS_OUT = 2'b11;
    #1;
    n_checks++; if (S_BUS_OUT !== 1'b1) begin n_fail++; $display("FAIL mux_nonowner_hi: got %b want 1", S_BUS_OUT); end
    M_BUS_OUT = 2'b01; M_RW = 2'b01;
    #1;
    n_checks++; if ({S_BUS_OUT, S_RW} !== 2'b00) begin n_fail++; $display("FAIL mux_nonowner_lo: got %b want 00", {S_BUS_OUT, S_RW}); end
    M_DONE = 2'b10;
    tick();
    M_BUS_OUT = 2'b10;
    #1;
    n_checks++; if (S_BUS_OUT !== 1'b0) begin n_fail++; $display("FAIL mux_no_owner: got %b want 0", S_BUS_OUT); end
    clear_inputs();
    tick();
  endtask

  task automatic test_stale_done();
    do_reset();
    M_DONE = 2'b01;
    M_REQ  = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if ({B_GRANT, BUS_BUSY} !== 3'b01_1) begin n_fail++; $display("FAIL stale_ignored: got %b want 011", {B_GRANT, BUS_BUSY}); end
    M_DONE = 2'b00;
    M_UTIL = 2'b01;
    tick();
    tick();
    n_checks++; if (B_GRANT !== 2'b01) begin n_fail++; $display("FAIL stale_busy_hold: got %b want 01", B_GRANT); end
    M_DONE = 2'b01;
    tick();
    n_checks++; if (B_GRANT !== 2'b00) begin n_fail++; $display("FAIL stale_done_rise: got %b want 00", B_GRANT); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    M_REQ = 2'b10;
    tick();
    M_UTIL = 2'b10;
    tick();
    n_checks++; if (B_GRANT !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre: got %b want 10", B_GRANT); end
    #1;
    RST = 1'b1;
    model_reset();
    #1;
    n_checks++; if ({B_GRANT, BUS_BUSY} !== 3'b00_0) begin n_fail++; $display("FAIL rstmid_async: got %b want 000", {B_GRANT, BUS_BUSY}); end
    #1;
    RST    = 1'b0;
    M_REQ  = 2'b11;
    M_UTIL = 2'b00;
    tick();
    n_checks++; if (B_GRANT !== 2'b01) begin n_fail++; $display("FAIL rstmid_first: got %b want 01", B_GRANT); end
    clear_inputs();
    tick();
    tick();
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    do_reset();
    M_REQ = 2'b11;
    tick();
    n_checks++; if (B_GRANT !== 2'b01) begin n_fail++; $display("FAIL to_grant0: got %b want 01", B_GRANT); end
    pulses = 0;
    for (int c = 1; c < TO; c++) begin
      tick();
      if (ARB_TIMEOUT === 1'b1) pulses++;
    end
    n_checks++; if ({B_GRANT, pulses[0]} !== 3'b01_0) begin n_fail++; $display("FAIL to_early: grant %b pulses %0d want 01/0", B_GRANT, pulses); end
    tick();
    n_checks++; if ({B_GRANT, ARB_TIMEOUT} !== 3'b00_1) begin n_fail++; $display("FAIL to_fire: got %b want 001", {B_GRANT, ARB_TIMEOUT}); end
    tick();
    n_checks++; if ({B_GRANT, ARB_TIMEOUT} !== 3'b00_0) begin n_fail++; $display("FAIL to_pulse_end: got %b want 000", {B_GRANT, ARB_TIMEOUT}); end
    tick();
    n_checks++; if (B_GRANT !== 2'b10) begin n_fail++; $display("FAIL to_next: got %b want 10", B_GRANT); end
    M_UTIL = 2'b10;
    for (int c = 0; c < 3 * TO; c++) tick();
    n_checks++; if ({B_GRANT, ARB_TIMEOUT} !== 3'b10_0) begin n_fail++; $display("FAIL to_busy_kept: got %b want 100", {B_GRANT, ARB_TIMEOUT}); end
    clear_inputs();
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] eg;
    logic         eb;
    logic [2:0]   es;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) M_REQ[i] = ~M_REQ[i];
      end
      M_UTIL    = N'($urandom_range(3) == 0 ? $urandom : 0);
      M_DONE    = N'($urandom);
      M_RW      = N'($urandom);
      M_BUS_OUT = N'($urandom);
      tick();
      eg = exp_grant();
      eb = (eg != '0);
      es = eb ? {M_BUS_OUT[m_owner], M_RW[m_owner], M_UTIL[m_owner]} : 3'b000;
      n_checks++;
      if ({B_GRANT, BUS_BUSY, OWNER_ID} !== {eg, eb, 1'(m_owner)}) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got grant %b busy %b owner %0d want %b %b %0d",
                 c, B_GRANT, BUS_BUSY, OWNER_ID, eg, eb, m_owner);
      end
      n_checks++;
      if ({S_BUS_OUT, S_RW, S_UTIL} !== es) begin
        n_fail++;
        $display("FAIL rand_smux[%0d]: got %b want %b", c, {S_BUS_OUT, S_RW, S_UTIL}, es);
      end
`ifdef BUS_ARB_TIMEOUT_EN
      n_checks++;
      if (ARB_TIMEOUT !== m_to) begin
        n_fail++;
        $display("FAIL rand_timeout[%0d]: got %b want %b", c, ARB_TIMEOUT, m_to);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    RST = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_mux();
    test_stale_done();
    test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates the shared single-wire serial bus among NUM_MASTERS bus masters.
- Takes each master's B_REQ, B_UTIL, B_DONE, B_RW and B_BUS_OUT, and returns a one-hot B_GRANT.
- Muxes the granted master's RW, serial data and UTIL onto the slave-side bus.
- Round-robin arbitration with a one-cycle turnaround between owners.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..8.
- TIMEOUT, 8, cycles a granted master may sit without asserting UTIL before the grant is revoked (only with the optional feature); legal range 2..255.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RST  in  1  asynchronous active-high reset.
- M_REQ  in  NUM_MASTERS  per-master bus request (master B_REQ, held for whole transaction).
- M_UTIL  in  NUM_MASTERS  per-master bus-in-use (master B_UTIL).
- M_DONE  in  NUM_MASTERS  per-master transaction complete (master B_DONE, level).
- M_RW  in  NUM_MASTERS  per-master read/write (master B_RW).
- M_BUS_OUT  in  NUM_MASTERS  per-master serial data out.
- B_GRANT  out  NUM_MASTERS  one-hot grant, registered.
- S_BUS_OUT  out  1  granted master's serial data, 0 when no owner.
- S_RW  out  1  granted master's RW, 0 when no owner.
- S_UTIL  out  1  granted master's UTIL, 0 when no owner.
- BUS_BUSY  out  1  high in ARMED or BUSY, registered.
- OWNER_ID  out  $clog2(NUM_MASTERS)  index of current or most recent owner.

Behaviour:
- Reset values:
  - state = IDLE, B_GRANT = 0, BUS_BUSY = 0, OWNER_ID = NUM_MASTERS-1, so master 0 wins first.
  - Timeout counter = 0.
  - S_* outputs = 0 because there is no owner.
- Reset asserted mid-transaction drops the grant immediately (async) and returns to IDLE.
- State machine:
  - IDLE: if any M_REQ bit is sampled high at an edge, select the first requester scanning OWNER_ID+1, OWNER_ID+2, … with wrap-around modulo NUM_MASTERS. At that same edge: B_GRANT[sel] = 1, OWNER_ID = sel, BUS_BUSY = 1, go to ARMED. Latency is M_REQ high -> B_GRANT high one edge later. With no request, stay in IDLE with all outputs 0.
  - ARMED: B_GRANT held.
    - M_UTIL[OWNER_ID] = 1 -> BUSY.
    - M_REQ[OWNER_ID] = 0 -> TURN.
    - Both high in the same cycle: REQ drop wins -> TURN.
  - BUSY: B_GRANT held.
    - M_DONE[OWNER_ID] = 1 or M_REQ[OWNER_ID] = 0 -> TURN.
    - M_DONE is evaluated only in BUSY. A stale DONE level left from the owner's previous transaction is therefore ignored, because the master clears DONE before raising UTIL.
  - TURN: exactly one cycle with B_GRANT = 0 and BUS_BUSY = 0; OWNER_ID is retained; then go to IDLE. A master that keeps M_REQ high re-competes and gets lowest priority.
- Grant rules:
  - B_GRANT is never multi-hot.
  - B_GRANT never changes owner without an intervening all-zero cycle.
  - Requests from non-owners never pre-empt the owner.
- Mux: S_BUS_OUT, S_RW and S_UTIL are combinational selects of M_*[OWNER_ID], gated by BUS_BUSY.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N-1,0. The maximum wait is (N-1) transactions.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ARMED and increments each cycle in ARMED.
  - If it reaches TIMEOUT with M_UTIL[OWNER_ID] still 0: go to TURN, and pulse output port ARB_TIMEOUT (1 bit, reset 0) high for one cycle.
  - BUSY is never timed out.
- Not defined: no counter and no ARB_TIMEOUT port. ARMED waits indefinitely for UTIL or a REQ drop.

Test Plan:
- Reset, then M_REQ = 2'b01 -> B_GRANT = 2'b01 one edge later, BUS_BUSY = 1, OWNER_ID = 0. M_UTIL[0] = 1 -> BUSY. M_DONE[0] = 1 -> one TURN cycle with B_GRANT = 0, then IDLE.
- M_REQ = 2'b11 held, each owner completes via UTIL then DONE -> grant order 01, 10, 01, 10, with one zero-grant cycle between each.
- Owner 1 in BUSY, M_BUS_OUT = 2'b10, M_RW = 2'b10 -> S_BUS_OUT = 1, S_RW = 1. Non-owner toggling its bus line has no effect on S_BUS_OUT.
- Stale DONE: M_DONE[0] = 1 held while master 0 is re-granted -> arbiter stays in ARMED (no TURN) until UTIL rises; then DONE must fall and re-rise to end the transaction.
- RST pulsed while in BUSY with owner 1 -> B_GRANT = 0 and BUS_BUSY = 0 immediately. After release, M_REQ = 2'b11 -> master 0 granted first.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT = 8: grant master 0 and never raise UTIL -> ARB_TIMEOUT pulses once 8 cycles after entering ARMED, B_GRANT drops, and pending master 1 is granted 2 cycles later.
